// File: rtl/pcileech_tlps128_cfgext_requester_if.sv
// Request/response handshake bundle between the config-request decoder (master)
// and the cfg_ext requester (slave).
interface pcileech_tlps128_cfgext_requester_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [9:0]  req_reg_num;
    logic [3:0]  req_func;
    logic [31:0] req_data;
    logic [3:0]  req_be;
    logic [7:0]  req_tag;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_write;
    logic [7:0]  rsp_tag;
    logic        rsp_timeout;

    modport master (
        output req_valid, req_write, req_reg_num, req_func, req_data, req_be, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_write, rsp_tag, rsp_timeout
    );

    modport slave (
        input  req_valid, req_write, req_reg_num, req_func, req_data, req_be, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_write, rsp_tag, rsp_timeout
    );
endinterface

// File: rtl/pcileech_tlps128_cfgext_requester.sv
// cfg_ext initiator: turns one decoded CfgRd/CfgWr into one strobe on the shadow BRAM port
// and returns one tagged response. Optional read timeout: define CFGEXT_REQ_TIMEOUT_EN.
module pcileech_tlps128_cfgext_requester #(
    parameter int          WR_SETTLE_CYCLES = 3,
    parameter int          TIMEOUT_CYCLES   = 64,
    parameter logic [31:0] TIMEOUT_DATA     = 32'hFFFFFFFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    pcileech_tlps128_cfgext_requester_if.slave io_req,
    output logic        o_cfg_ext_read_received,
    output logic        o_cfg_ext_write_received,
    output logic [9:0]  o_cfg_ext_register_number,
    output logic [3:0]  o_cfg_ext_function_number,
    output logic [31:0] o_cfg_ext_write_data,
    output logic [3:0]  o_cfg_ext_write_byte_enable,
    input  logic [31:0] i_cfg_ext_read_data,
    input  logic        i_cfg_ext_read_data_valid,
    output logic        o_busy
);

    localparam logic [7:0] LP_WR_SETTLE = 8'(WR_SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RD,
        S_WAIT_WR,
        S_RESP
    } state_t;

    state_t      r_state;
    logic        r_req_ready;
    logic        r_busy;
    logic        r_rd_stb;
    logic        r_wr_stb;
    logic        r_write;
    logic [9:0]  r_reg_num;
    logic [3:0]  r_func;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [7:0]  r_tag;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_rsp_write;
    logic [7:0]  r_rsp_tag;
    logic [7:0]  r_wr_cnt;

    logic        w_accept;
    logic [7:0]  w_wr_cnt_nxt;

    assign w_accept     = io_req.req_valid & r_req_ready;
    assign w_wr_cnt_nxt = r_wr_cnt + 8'd1;

`ifdef CFGEXT_REQ_TIMEOUT_EN
    localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);

    logic        r_rsp_timeout;
    logic [15:0] r_to_cnt;
    logic [15:0] w_to_cnt_nxt;

    // Saturates so a huge TIMEOUT_CYCLES can never wrap back below the limit.
    assign w_to_cnt_nxt       = (r_to_cnt == 16'hFFFF) ? r_to_cnt : r_to_cnt + 16'd1;
    assign io_req.rsp_timeout = r_rsp_timeout;
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = ^{TIMEOUT_DATA, 16'(TIMEOUT_CYCLES)};
    assign io_req.rsp_timeout   = 1'b0;
`endif

    assign io_req.req_ready = r_req_ready;
    assign io_req.rsp_valid = r_rsp_valid;
    assign io_req.rsp_data  = r_rsp_data;
    assign io_req.rsp_write = r_rsp_write;
    assign io_req.rsp_tag   = r_rsp_tag;

    assign o_cfg_ext_read_received     = r_rd_stb;
    assign o_cfg_ext_write_received    = r_wr_stb;
    assign o_cfg_ext_register_number   = r_reg_num;
    assign o_cfg_ext_function_number   = r_func;
    assign o_cfg_ext_write_data        = r_wdata;
    assign o_cfg_ext_write_byte_enable = r_be;
    assign o_busy                      = r_busy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b0;
            r_busy        <= 1'b0;
            r_rd_stb      <= 1'b0;
            r_wr_stb      <= 1'b0;
            r_write       <= 1'b0;
            r_reg_num     <= '0;
            r_func        <= '0;
            r_wdata       <= '0;
            r_be          <= '0;
            r_tag         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_write   <= 1'b0;
            r_rsp_tag     <= '0;
            r_wr_cnt      <= '0;
`ifdef CFGEXT_REQ_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
            r_to_cnt      <= '0;
`endif
        end else begin
            r_rd_stb <= 1'b0;
            r_wr_stb <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        // Strobe is registered here so it is high for exactly the ISSUE cycle.
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_write     <= io_req.req_write;
                        r_reg_num   <= io_req.req_reg_num;
                        r_func      <= io_req.req_func;
                        r_wdata     <= io_req.req_data;
                        r_be        <= io_req.req_be;
                        r_tag       <= io_req.req_tag;
                        r_rd_stb    <= ~io_req.req_write;
                        r_wr_stb    <= io_req.req_write;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_write) begin
                        r_wr_cnt <= 8'd1;
                        r_state  <= S_WAIT_WR;
                    end else begin
`ifdef CFGEXT_REQ_TIMEOUT_EN
                        r_to_cnt <= 16'd1;
`endif
                        r_state  <= S_WAIT_RD;
                    end
                end
                S_WAIT_RD: begin
                    // Read data takes priority over a timeout expiring in the same cycle.
                    if (i_cfg_ext_read_data_valid) begin
                        r_rsp_data    <= i_cfg_ext_read_data;
                        r_rsp_write   <= 1'b0;
                        r_rsp_tag     <= r_tag;
                        r_rsp_valid   <= 1'b1;
`ifdef CFGEXT_REQ_TIMEOUT_EN
                        r_rsp_timeout <= 1'b0;
`endif
                        r_state       <= S_RESP;
                    end
`ifdef CFGEXT_REQ_TIMEOUT_EN
                    else begin
                        r_to_cnt <= w_to_cnt_nxt;
                        if (w_to_cnt_nxt >= LP_TIMEOUT) begin
                            r_rsp_data    <= TIMEOUT_DATA;
                            r_rsp_write   <= 1'b0;
                            r_rsp_tag     <= r_tag;
                            r_rsp_valid   <= 1'b1;
                            r_rsp_timeout <= 1'b1;
                            r_state       <= S_RESP;
                        end
                    end
`endif
                end
                S_WAIT_WR: begin
                    r_wr_cnt <= w_wr_cnt_nxt;
                    if (w_wr_cnt_nxt >= LP_WR_SETTLE) begin
                        r_rsp_data    <= '0;
                        r_rsp_write   <= 1'b1;
                        r_rsp_tag     <= r_tag;
                        r_rsp_valid   <= 1'b1;
`ifdef CFGEXT_REQ_TIMEOUT_EN
                        r_rsp_timeout <= 1'b0;
`endif
                        r_state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (io_req.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
